// File: rtl/branch_target_predictor.sv
// branch_target_predictor: fetch PC unit with a direct-mapped BTB, 2-bit direction counters,
// misprediction redirect and saturating branch statistics.
module branch_target_predictor #(
    parameter logic [31:0] PC_INIT = 32'h0,
    parameter int          ENTRIES = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        pc_en,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        res_valid,
    input  logic [31:0] res_pc,
    input  logic        res_is_cond,
    input  logic        res_taken,
    input  logic [31:0] res_target,
    input  logic        res_pred_taken,
    input  logic [31:0] res_pred_target,
    output logic        mispredict,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic             valid_q  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [29:0]      target_q [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [31:0]      pc_q, pc_d, br_q, br_d, mp_q, mp_d;
    logic [IDX_W-1:0] idx, ridx;
    logic             hit, rhit, wr_en;
    logic [1:0]       rctr, wr_ctr;
    logic [29:0]      wr_target;

    assign idx         = pc_q[IDX_W+1:2];
    assign hit         = valid_q[idx] && (tag_q[idx] == pc_q[31:IDX_W+2]);
    assign pred_taken  = hit & ctr_q[idx][1];
    assign pred_target = hit ? {target_q[idx], 2'b00} : 32'h0;
    assign ridx        = res_pc[IDX_W+1:2];
    assign rhit        = valid_q[ridx] && (tag_q[ridx] == res_pc[31:IDX_W+2]);
    assign rctr        = ctr_q[ridx];
    assign mispredict  = res_valid & ((res_taken != res_pred_taken) |
                                      (res_taken & (res_target != res_pred_target)));
    assign pc            = pc_q;
    assign stat_branches = br_q;
    assign stat_mispred  = mp_q;

    always_comb begin
        pc_d = mispredict ? (res_taken ? res_target : res_pc + 32'd4)
             : pc_en ? (pred_taken ? pred_target : pc_q + 32'd4) : pc_q;
        br_d = (res_valid && br_q != 32'hFFFF_FFFF) ? br_q + 32'd1 : br_q;
        mp_d = (mispredict && mp_q != 32'hFFFF_FFFF) ? mp_q + 32'd1 : mp_q;
        // Allocate only on taken misses; a not-taken miss leaves the table alone.
        wr_en = res_valid & (rhit | res_taken);
        wr_ctr = !rhit ? (res_is_cond ? 2'b10 : 2'b11)
               : !res_is_cond ? 2'b11
               : res_taken ? (rctr == 2'b11 ? rctr : rctr + 2'd1)
               : (rctr == 2'b00 ? rctr : rctr - 2'd1);
        wr_target = (rhit & !res_taken) ? target_q[ridx] : res_target[31:2];
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc_q <= PC_INIT;
            br_q <= '0;
            mp_q <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                ctr_q[i]    <= 2'b01;
            end
        end else begin
            pc_q <= pc_d;
            br_q <= br_d;
            mp_q <= mp_d;
            if (wr_en) begin
                valid_q[ridx]  <= 1'b1;
                tag_q[ridx]    <= res_pc[31:IDX_W+2];
                target_q[ridx] <= wr_target;
                ctr_q[ridx]    <= wr_ctr;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_predictor.sv
// tb_branch_target_predictor: directed checks of fetch PC, BTB prediction, redirect and stats.
module tb_branch_target_predictor;
    logic        CLK = 1'b0, nRST = 1'b0, pc_en = 1'b0;
    logic [31:0] pc, pred_target, res_pc = '0, res_target = '0, res_pred_target = '0;
    logic        pred_taken, res_valid = 1'b0, res_is_cond = 1'b0, res_taken = 1'b0;
    logic        res_pred_taken = 1'b0, mispredict;
    logic [31:0] stat_branches, stat_mispred;
    int total = 0, bad = 0;

    branch_target_predictor #(.PC_INIT(32'h0), .ENTRIES(16)) dut (
        .CLK(CLK), .nRST(nRST), .pc_en(pc_en), .pc(pc), .pred_taken(pred_taken),
        .pred_target(pred_target), .res_valid(res_valid), .res_pc(res_pc),
        .res_is_cond(res_is_cond), .res_taken(res_taken), .res_target(res_target),
        .res_pred_taken(res_pred_taken), .res_pred_target(res_pred_target),
        .mispredict(mispredict), .stat_branches(stat_branches), .stat_mispred(stat_mispred)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic [31:0] rpc, input logic cond, input logic tkn,
                         input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt);
        res_valid = 1'b1; res_pc = rpc; res_is_cond = cond; res_taken = tkn;
        res_target = tgt; res_pred_taken = ptkn; res_pred_target = ptgt;
        #1;
    endtask

    task automatic resolve(input logic [31:0] rpc, input logic cond, input logic tkn,
                           input logic [31:0] tgt, input logic ptkn, input logic [31:0] ptgt);
        drive(rpc, cond, tkn, tgt, ptkn, ptgt);
        tick();
        res_valid = 1'b0;
        #1;
    endtask

    // Steer pc to a via a mispredicted not-taken branch at a-4 (slot kept empty).
    task automatic redirect(input logic [31:0] a);
        resolve(a - 32'd4, 1'b1, 1'b0, 32'h0, 1'b1, 32'h0);
    endtask

    initial begin
        #1;
        chk("rst_pc", pc, 32'h0);
        chk("rst_pred", {31'b0, pred_taken}, 32'h0);
        chk("rst_br", stat_branches, 32'h0);
        #11 nRST = 1'b1;
        // 1: sequential fetch then hold
        pc_en = 1'b1;
        tick(); chk("seq4", pc, 32'h4);
        tick(); chk("seq8", pc, 32'h8);
        tick(); chk("seq12", pc, 32'hC);
        pc_en = 1'b0;
        tick(); tick(); chk("hold12", pc, 32'hC);
        chk("seq_pred", {31'b0, pred_taken}, 32'h0);
        chk("seq_stats", stat_branches | stat_mispred, 32'h0);
        // 2: cold conditional taken
        drive(32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h0);
        chk("cold_mp", {31'b0, mispredict}, 32'h1);
        tick(); res_valid = 1'b0; #1;
        chk("cold_pc", pc, 32'h40);
        chk("cold_br", stat_branches, 32'h1);
        chk("cold_mpc", stat_mispred, 32'h1);
        redirect(32'h10);
        chk("r10_pc", pc, 32'h10);
        chk("r10_pt", {31'b0, pred_taken}, 32'h1);
        chk("r10_tg", pred_target, 32'h40);
        // 3: hysteresis; same-cycle lookup still sees old entry
        drive(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("nt_mp", {31'b0, mispredict}, 32'h1);
        chk("same_cyc_pt", {31'b0, pred_taken}, 32'h1);
        tick(); res_valid = 1'b0; #1;
        chk("nt_pc", pc, 32'h14);
        redirect(32'h10);
        chk("ctr01_pt", {31'b0, pred_taken}, 32'h0);
        chk("ctr01_tg", pred_target, 32'h40);
        chk("stats4", stat_branches, 32'h4);
        drive(32'h10, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
        chk("tk_nomp", {31'b0, mispredict}, 32'h0);
        tick(); res_valid = 1'b0; #1;
        chk("tk_hold_pc", pc, 32'h10);
        chk("ctr10_pt", {31'b0, pred_taken}, 32'h1);
        resolve(32'h10, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
        resolve(32'h10, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40);
        chk("br7", stat_branches, 32'h7);
        chk("mp4", stat_mispred, 32'h4);
        resolve(32'h10, 1'b1, 1'b0, 32'h0, 1'b1, 32'h40);
        chk("nt2_pc", pc, 32'h14);
        redirect(32'h10);
        chk("sat_pt", {31'b0, pred_taken}, 32'h1);
        // 4: aliasing at index 4
        redirect(32'h50);
        chk("alias_miss_pt", {31'b0, pred_taken}, 32'h0);
        chk("alias_miss_tg", pred_target, 32'h0);
        resolve(32'h50, 1'b1, 1'b1, 32'h80, 1'b0, 32'h0);
        chk("alias_pc", pc, 32'h80);
        redirect(32'h50);
        chk("alias_pt", {31'b0, pred_taken}, 32'h1);
        chk("alias_tg", pred_target, 32'h80);
        redirect(32'h10);
        chk("evict_pt", {31'b0, pred_taken}, 32'h0);
        chk("evict_tg", pred_target, 32'h0);
        chk("br13", stat_branches, 32'd13);
        chk("mp10", stat_mispred, 32'd10);
        // 5: jr allocation and target change
        resolve(32'h20, 1'b0, 1'b1, 32'h100, 1'b0, 32'h0);
        chk("jr_pc", pc, 32'h100);
        redirect(32'h20);
        chk("jr_pt", {31'b0, pred_taken}, 32'h1);
        chk("jr_tg", pred_target, 32'h100);
        drive(32'h20, 1'b0, 1'b1, 32'h200, 1'b1, 32'h100);
        chk("jr_mp", {31'b0, mispredict}, 32'h1);
        chk("jr_old_tg", pred_target, 32'h100);
        tick(); res_valid = 1'b0; #1;
        chk("jr2_pc", pc, 32'h200);
        redirect(32'h20);
        chk("jr_new_tg", pred_target, 32'h200);
        // 6: predicted fetch, then mispredict wins over pc_en
        pc_en = 1'b1;
        tick(); chk("pred_fetch", pc, 32'h200);
        tick(); chk("pc4_fetch", pc, 32'h204);
        redirect(32'h20);
        chk("mp_over_en", pc, 32'h20);
        pc_en = 1'b0;
        chk("br18", stat_branches, 32'd18);
        chk("mp15", stat_mispred, 32'd15);
        // reset mid-run with a resolution in flight
        drive(32'h30, 1'b1, 1'b1, 32'h300, 1'b0, 32'h0);
        nRST = 1'b0; #1;
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_br", stat_branches, 32'h0);
        chk("mid_rst_mp", stat_mispred, 32'h0);
        res_valid = 1'b0;
        @(negedge CLK); nRST = 1'b1; #1;
        redirect(32'h20);
        chk("clr_pt", {31'b0, pred_taken}, 32'h0);
        chk("clr_tg", pred_target, 32'h0);
        chk("clr_br", stat_branches, 32'h1);
        // res_pc+4 wraps
        redirect(32'h0);
        chk("wrap_pc", pc, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

- Parametrised fetch-stage PC unit. It replaces the fixed pc4/jump/branch next-PC mux with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters.
- It drives the instruction fetch address and predicts the next PC every cycle.
- It accepts one control-flow resolution per cycle from the EX/MEM boundary and raises a redirect (flush) on misprediction.
- It keeps branch and mispredict statistics counters.

## Interface
Parameters:
- PC_INIT, 32'h0: PC value loaded on reset.
- ENTRIES, 16: number of BTB entries. Power of two, 2..256. IDX_W = $clog2(ENTRIES); tag width TAG_W = 30-IDX_W.

Ports:
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- pc_en  in  1  advance PC this cycle (ihit & !dhit).
- pc  out  32  current fetch address (to imemaddr).
- pred_taken  out  1  prediction for pc: BTB hit and counter MSB set.
- pred_target  out  32  predicted target for pc, {entry.target,2'b00}. 0 on miss.
- res_valid  in  1  one control-flow instruction resolves this cycle. Pulsed exactly one cycle per instruction.
- res_pc  in  32  PC of the resolving instruction.
- res_is_cond  in  1  1 = beq/bne; 0 = j/jal/jr.
- res_taken  in  1  actual direction. Must be 1 when res_is_cond=0.
- res_target  in  32  actual target address.
- res_pred_taken  in  1  prediction carried down the pipe with the instruction.
- res_pred_target  in  32  predicted target carried down the pipe with the instruction.
- mispredict  out  1  redirect/flush request for IF/ID and ID/EX (combinational).
- stat_branches  out  32  count of res_valid cycles.
- stat_mispred  out  32  count of mispredict cycles.

## Operation
Entry contents: valid, tag = addr[31:IDX_W+2], target[31:2], ctr[1:0].

Lookup (combinational on pc):
- Index = pc[IDX_W+1:2].
- hit = valid & (tag == pc[31:IDX_W+2]).

Mispredict rule:
- mispredict = res_valid & ((res_taken != res_pred_taken) | (res_taken & res_target != res_pred_target)).

Next PC, evaluated in priority order:
- mispredict: res_taken ? res_target : res_pc+4. Applied regardless of pc_en.
- pc_en: pred_taken ? pred_target : pc+4.
- Otherwise: hold.

BTB update on res_valid (indexed by res_pc):
- Tag hit, conditional: if taken, ctr saturating increment (max 11) and target <= res_target[31:2]; if not taken, ctr saturating decrement (min 00), target unchanged.
- Tag hit, unconditional: ctr <= 11, target <= res_target[31:2].
- Tag miss, taken: allocate/overwrite the entry: valid=1, new tag, target. ctr = 10 for conditional, 11 for unconditional.
- Tag miss, not taken: no change.

Statistics:
- stat_branches increments on res_valid.
- stat_mispred increments on mispredict.
- Both saturate at 32'hFFFFFFFF.

Arithmetic: pc+4 and res_pc+4 wrap modulo 2^32. Bits [1:0] of res_target are ignored for storage.

## Timing
Reset (async, immediate):
- pc=PC_INIT, all valid=0, all ctr=01, stats=0.
- Outputs as a result: pred_taken=0, pred_target=0, mispredict follows its inputs.

Latency:
- Lookup: 0 cycles. pred_* are valid in the same cycle as pc.
- Redirect: mispredict is asserted in the res_valid cycle; pc shows the corrected address after the next rising edge.

Boundary conditions:
- Same-cycle update and lookup to the same index: the lookup sees pre-update contents. The update is visible from the next cycle.
- Aliasing: a different tag at the same index misses. A taken resolution evicts the old tag.
- mispredict with pc_en=0: redirect still happens; the predicted PC is discarded.
- res_valid with no mispredict: only the BTB and stats update; pc follows the pc_en rule.
- Reset asserted mid-operation: the table is cleared and the in-flight resolution is dropped.

## Test plan
All scenarios use ENTRIES=16 and PC_INIT=0.

1. Reset, then pc_en=1 for 3 cycles, then pc_en=0 for 2 cycles -> pc = 0, 4, 8, 12, 12, 12; pred_taken=0 throughout; stats remain 0.
2. Cold conditional taken branch:
   - Stimulus: res_valid, res_pc=0x10, cond, taken, res_target=0x40, res_pred_taken=0.
   - Required: mispredict=1; next pc=0x40; stat_branches=1, stat_mispred=1.
   - Then drive pc to 0x10: pred_taken=1, pred_target=0x40.
3. Counter hysteresis on the 0x10 entry (ctr=10):
   - One not-taken resolution with pred_taken=1 -> mispredict, pc=0x14, ctr=01; lookup of 0x10 gives pred_taken=0.
   - Three taken resolutions -> ctr saturates at 11.
   - One not-taken then drops ctr to 10; prediction stays taken.
4. Aliasing: with 0x10 allocated, lookup of 0x50 (same index 4) -> miss. A taken resolution at 0x50 with target 0x80 -> lookup of 0x50 gives 0x80; lookup of 0x10 now misses.
5. jr target change:
   - Uncond res_pc=0x20, target 0x100 -> allocated with ctr=11.
   - Then res_pred_taken=1, res_pred_target=0x100, res_target=0x200 -> mispredict, pc=0x200; entry target becomes 0x200.
6. Simultaneous events:
   - Mispredict with pc_en=0 -> redirect still taken.
   - Update to the index currently being looked up -> the old prediction is shown this cycle, the new one next cycle.
   - nRST pulsed mid-run -> pc=0 immediately, table and stats cleared.
